video_pixel_gen: RTL and testbench
==================================

# video_pixel_gen

Character-mode pixel generator for the PET display path, fed by the video timing stage's line/frame strobes. Per character cell it fetches the screen code from VRAM and the glyph row from the character ROM image over the system bus. A fetch request/acknowledge handshake with the bus arbiter carries these reads. It then serializes the glyph to `video_o` at 8 MHz, one pixel per two `clk_16_i` cycles. Bit 7 of the screen code selects reverse video.

## Interface
- `COLUMNS`, 40, characters per row (40 or 80)
- `ROWS`, 25, character rows per frame
- `CHAR_LINES`, 8, scanlines per character row (fixed 8; glyph line index is 3 bits)
- `VRAM_BASE`, 17'h0_8000, bus address of screen code (row 0, col 0)
- `CHAR_BASE`, 17'h1_0000, bus address of 2 KB character ROM image

- `clk_16_i`  in  1  16 MHz system clock
- `reset_ni`  in  1  reset, asynchronous, active-low
- `frame_start_i`  in  1  one-cycle pulse, start of frame
- `line_start_i`  in  1  one-cycle pulse, start of a displayable scanline
- `gfx_i`  in  1  character set select (glyph address bit 10)
- `fetch_req_o`  out  1  bus read request
- `fetch_addr_o`  out  17  bus read address, stable while `fetch_req_o`=1
- `fetch_ack_i`  in  1  read complete; `fetch_data_i` valid this cycle
- `fetch_data_i`  in  8  read data
- `video_o`  out  1  pixel output, 1 = lit
- `active_o`  out  1  pixels of a valid row/line are being shifted
- `underrun_o`  out  1  sticky: a glyph missed its deadline this frame

## Operation
- Counters: `col` (0..COLUMNS-1), `line` (0..7), `row` (0..ROWS-1), `row_base` (=row*COLUMNS, maintained by adding COLUMNS; no multiplier).
- `frame_start_i`: row=0, line=0, row_base=0, `underrun_o`=0, `active_o`=0, `video_o`=0, current line abandoned.
- `line_start_i` with row<ROWS: begin line at col=0. With row≥ROWS: ignored, video stays 0.
- End of line (last pixel of col COLUMNS-1 done): line++; at line 7→0, row++ and row_base+=COLUMNS.
- Fetch FSM: IDLE → CODE (addr = VRAM_BASE+row_base+col) → GLYPH (addr = CHAR_BASE+{gfx_i, code[6:0], line[2:0]}) → HOLD (glyph+reverse bit buffered until char boundary) → CODE for col+1, or IDLE after last column.
- Handshake: req rises with addr valid; req and addr held until the cycle ack=1; data captured on ack; req deasserts the cycle after ack; a new req may rise no earlier than the following cycle.
- Boundary load: shifter ← buffered glyph XOR {8{code[7]}}. If glyph not buffered: shifter ← 8'h00, underrun_o ← 1. An outstanding req still completes; its data is discarded; FSM moves on to the next column.
- Shift: MSB first, shift every 2nd cycle; `video_o` = shifter[7] while active, else 0.

## Timing
- Reset values: all outputs 0, FSM IDLE, all counters 0.
- `line_start_i` at cycle T: `fetch_req_o` for col 0 at T+1. Col 0 pixel 0 on `video_o` at T+16. Col k pixel p spans T+16+16k+2p and the following cycle.
- `active_o` high T+16 through T+15+16·COLUMNS; `video_o`=0 otherwise.
- Per-character budget: 16 cycles for two fetches; zero-wait ack gives 4 cycles.
- `line_start_i` during an active line restarts at col 0 without advancing line/row; pending req completes, data discarded.
- `frame_start_i` and `line_start_i` in the same cycle: frame reset applied, then line row 0/line 0 starts (req at T+1).
- `reset_ni` low mid-fetch: req drops immediately (async); the arbiter discards the transaction.

## Structure
- Package `video_pkg`: CHAR_CLKS=16, PIXEL_CLKS=2, GLYPH_LINE_BITS=3, fetch state enum (IDLE, CODE, GLYPH, HOLD).
- Sub-module `video_shifter`: 8-bit load/shift register with reverse XOR, load and pixel-phase enables.

## Test plan
- Zero-wait ack; VRAM[$8000]=$01, ROM[$10008]=$3C, gfx=0, line 0: line_start at T → addr $08000 at T+1 then $10008; video_o 0,0,1,1,1,1,0,0 (each 2 cycles) from T+16.
- VRAM[$8000]=$81, same glyph → pixels 1,1,0,0,0,0,1,1.
- 8 line_starts then one more: 9th line code addr = $08028, glyph line index 0. Also gfx=1 on line 3 of code $01 → glyph addr $1040B.
- Ack delayed 20 cycles on col 0 → col 0 pixels all 0, underrun_o=1; col 1 displays correctly; underrun_o clears on frame_start.
- 25×8 lines then an extra line_start → no fetch_req, video_o=0, active_o=0.
- reset_ni low while req held → req, video_o, active_o 0 same cycle; after release the next line_start fetches $08000.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants and the fetch state type for the character-mode pixel generator.
package video_pkg;
    localparam int CHAR_CLKS       = 16;
    localparam int PIXEL_CLKS      = 2;
    localparam int GLYPH_LINE_BITS = 3;

    typedef enum logic [1:0] {
        IDLE,
        CODE,
        GLYPH,
        HOLD
    } fetch_state_e;
endpackage

// File: rtl/video_shifter.sv
// Glyph row shifter: loads a (possibly inverted) glyph and shifts it out MSB first.
module video_shifter (
    input  logic       clk_16_i,
    input  logic       reset_ni,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] glyph_i,
    input  logic       reverse_i,
    output logic       pixel_o
);
    logic [7:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (clr_i) begin
            sh_d = 8'h00;
        end else if (load_i) begin
            sh_d = glyph_i ^ {8{reverse_i}};
        end else if (shift_i) begin
            sh_d = {sh_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk_16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sh_q <= 8'h00;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign pixel_o = sh_q[7];
endmodule

// File: rtl/video_pixel_gen.sv
// Character-mode pixel generator: fetches screen code and glyph row per cell, shifts pixels out.
module video_pixel_gen
    import video_pkg::*;
#(
    parameter int          COLUMNS    = 40,
    parameter int          ROWS       = 25,
    parameter int          CHAR_LINES = 8,
    parameter logic [16:0] VRAM_BASE  = 17'h0_8000,
    parameter logic [16:0] CHAR_BASE  = 17'h1_0000
) (
    input  logic        clk_16_i,
    input  logic        reset_ni,
    input  logic        frame_start_i,
    input  logic        line_start_i,
    input  logic        gfx_i,
    output logic        fetch_req_o,
    output logic [16:0] fetch_addr_o,
    input  logic        fetch_ack_i,
    input  logic [7:0]  fetch_data_i,
    output logic        video_o,
    output logic        active_o,
    output logic        underrun_o
);
    localparam int COL_W = $clog2(COLUMNS);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int CNT_W = $clog2(CHAR_CLKS);

    fetch_state_e               state_q, state_d;
    logic                       req_q, req_d;
    logic [16:0]                addr_q, addr_d;
    logic                       discard_q, discard_d;
    logic [7:0]                 code_q, code_d;
    logic [7:0]                 glyph_q, glyph_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [GLYPH_LINE_BITS-1:0] line_q, line_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [16:0]                row_base_q, row_base_d;
    logic                       run_q, run_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       active_q, active_d;
    logic                       last_q, last_d;
    logic                       underrun_q, underrun_d;

    logic       boundary, pending, sh_clr, sh_load, sh_shift, sh_rev, pixel;
    logic [7:0] sh_glyph;

    assign boundary = run_q && (cnt_q == CNT_W'(CHAR_CLKS - 1));
    assign pending  = req_q && !fetch_ack_i;
    assign sh_shift = active_q && !boundary
                      && ((cnt_q % CNT_W'(PIXEL_CLKS)) == CNT_W'(PIXEL_CLKS - 1));

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        code_d     = code_q;
        glyph_d    = glyph_q;
        col_d      = col_q;
        line_d     = line_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        last_d     = last_q;
        underrun_d = underrun_q;
        sh_clr     = 1'b0;
        sh_load    = 1'b0;
        sh_glyph   = 8'h00;
        sh_rev     = 1'b0;

        if (run_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A new request only rises from a cycle where req is already low, giving the gap after ack.
        if (req_q && fetch_ack_i) begin
            req_d = 1'b0;
            if (discard_q) begin
                discard_d = 1'b0;
            end else if (state_q == CODE) begin
                code_d  = fetch_data_i;
                state_d = GLYPH;
            end else if (state_q == GLYPH) begin
                glyph_d = fetch_data_i;
                state_d = HOLD;
            end
        end else if (!req_q && state_q == CODE) begin
            req_d  = 1'b1;
            addr_d = VRAM_BASE + row_base_q + 17'(col_q);
        end else if (!req_q && state_q == GLYPH) begin
            req_d  = 1'b1;
            addr_d = CHAR_BASE + {6'b0, gfx_i, code_q[6:0], line_q};
        end

        if (boundary) begin
            if (last_q) begin
                run_d    = 1'b0;
                active_d = 1'b0;
                last_d   = 1'b0;
                if (line_q == GLYPH_LINE_BITS'(CHAR_LINES - 1)) begin
                    line_d     = '0;
                    row_d      = row_q + ROW_W'(1);
                    row_base_d = row_base_q + 17'(COLUMNS);
                end else begin
                    line_d = line_q + GLYPH_LINE_BITS'(1);
                end
            end else begin
                active_d = 1'b1;
                sh_load  = 1'b1;
                if (state_q == HOLD) begin
                    sh_glyph = glyph_q;
                    sh_rev   = code_q[7];
                end else begin
                    underrun_d = 1'b1;
                end
                if (pending) begin
                    discard_d = 1'b1;
                end else begin
                    req_d = 1'b0;
                end
                if (col_q == COL_W'(COLUMNS - 1)) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else begin
                    state_d = CODE;
                    col_d   = col_q + COL_W'(1);
                end
            end
        end

        if (frame_start_i) begin
            row_d      = '0;
            line_d     = '0;
            row_base_d = '0;
            underrun_d = 1'b0;
            active_d   = 1'b0;
            run_d      = 1'b0;
            last_d     = 1'b0;
            state_d    = IDLE;
            sh_clr     = 1'b1;
            if (pending) begin
                discard_d = 1'b1;
            end else begin
                req_d = 1'b0;
            end
        end

        // row_d already reflects a same-cycle frame reset, so frame+line starts row 0 at once.
        if (line_start_i && (row_d < ROW_W'(ROWS))) begin
            col_d    = '0;
            run_d    = 1'b1;
            cnt_d    = CNT_W'(1);
            active_d = 1'b0;
            last_d   = 1'b0;
            state_d  = CODE;
            sh_clr   = 1'b1;
            if (pending) begin
                discard_d = 1'b1;
            end else if (!req_q) begin
                req_d  = 1'b1;
                addr_d = VRAM_BASE + row_base_d;
            end
        end
    end

    always_ff @(posedge clk_16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            discard_q  <= 1'b0;
            code_q     <= '0;
            glyph_q    <= '0;
            col_q      <= '0;
            line_q     <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            run_q      <= 1'b0;
            cnt_q      <= '0;
            active_q   <= 1'b0;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
            code_q     <= code_d;
            glyph_q    <= glyph_d;
            col_q      <= col_d;
            line_q     <= line_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            run_q      <= run_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
        end
    end

    video_shifter u_shifter (
        .clk_16_i  (clk_16_i),
        .reset_ni  (reset_ni),
        .clr_i     (sh_clr),
        .load_i    (sh_load),
        .shift_i   (sh_shift),
        .glyph_i   (sh_glyph),
        .reverse_i (sh_rev),
        .pixel_o   (pixel)
    );

    assign fetch_req_o  = req_q;
    assign fetch_addr_o = addr_q;
    assign active_o     = active_q;
    assign video_o      = active_q & pixel;
    assign underrun_o   = underrun_q;
endmodule

// File: tb/tb_video_pixel_gen.sv
// Directed bench for video_pixel_gen with a small VRAM/ROM bus responder.
`timescale 1ns/1ps
module tb_video_pixel_gen;
    localparam int COLS    = 40;
    localparam int TB_ROWS = 4;   // short frame keeps the full-frame run brief
    localparam int LINE_T  = 16 * (COLS + 1) + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        gfx = 1'b0;
    logic        fetch_req;
    logic [16:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic [7:0]  fetch_data = 8'h00;
    logic        video, active, underrun;

    int cyc = 0, checks = 0, errors = 0, t0 = 0;
    int delay_next = 0, cur_delay = 0, rq_cnt = 0;
    logic [7:0] vram [2048];
    logic [7:0] rom  [2048];

    video_pixel_gen #(.COLUMNS(COLS), .ROWS(TB_ROWS)) dut (
        .clk_16_i      (clk),
        .reset_ni      (rst_n),
        .frame_start_i (frame_start),
        .line_start_i  (line_start),
        .gfx_i         (gfx),
        .fetch_req_o   (fetch_req),
        .fetch_addr_o  (fetch_addr),
        .fetch_ack_i   (fetch_ack),
        .fetch_data_i  (fetch_data),
        .video_o       (video),
        .active_o      (active),
        .underrun_o    (underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_rd(input logic [16:0] a);
        if (a >= 17'h10000) return rom[a[10:0]];
        return vram[a[10:0]];
    endfunction

    // Bus responder: ack after cur_delay cycles of a held request (0 = same cycle).
    always @(posedge clk) begin
        #1;
        if (!fetch_req) begin
            fetch_ack = 1'b0;
            rq_cnt    = 0;
        end else begin
            if (rq_cnt == 0) begin
                cur_delay  = delay_next;
                delay_next = 0;
            end
            if (rq_cnt >= cur_delay) begin
                fetch_ack  = 1'b1;
                fetch_data = mem_rd(fetch_addr);
            end else begin
                fetch_ack = 1'b0;
            end
            rq_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
        $display("[cyc %0d] %s observed=%0h expected=%0h", cyc, tag, obs, exp_v);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic fs, input logic ls);
        frame_start = fs;
        line_start  = ls;
        t0          = cyc;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        line_start  = 1'b0;
    endtask

    task automatic chk_pixels(input string tag, input int base, input logic [7:0] pat);
        for (int p = 0; p < 8; p++) begin
            wait_cyc(base + 2 * p);
            chk(tag, 32'(video), 32'(pat[7-p]));
        end
    endtask

    task automatic run_line();
        pulse(1'b0, 1'b1);
        wait_cyc(t0 + LINE_T);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            vram[i] = 8'h20;
            rom[i]  = 8'h00;
        end
        vram[0]  = 8'h01;
        vram[40] = 8'h05;
        vram[41] = 8'h01;
        rom[8]   = 8'h3C;
        rom[9]   = 8'h3C;

        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_req", 32'(fetch_req), 32'd0);
        chk("reset_video", 32'(video), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Line 0: code $01, glyph $3C
        pulse(1'b0, 1'b1);
        chk("l0_req_t1", 32'(fetch_req), 32'd1);
        chk("l0_code_addr", 32'(fetch_addr), 32'h08000);
        wait_cyc(t0 + 2);
        chk("l0_req_gap", 32'(fetch_req), 32'd0);
        wait_cyc(t0 + 3);
        chk("l0_glyph_req", 32'(fetch_req), 32'd1);
        chk("l0_glyph_addr", 32'(fetch_addr), 32'h10008);
        wait_cyc(t0 + 15);
        chk("l0_active_pre", 32'(active), 32'd0);
        wait_cyc(t0 + 16);
        chk("l0_active_first", 32'(active), 32'd1);
        chk_pixels("l0_pix", t0 + 16, 8'b0011_1100);
        wait_cyc(t0 + 15 + 16 * COLS);
        chk("l0_active_last", 32'(active), 32'd1);
        wait_cyc(t0 + 16 + 16 * COLS);
        chk("l0_active_end", 32'(active), 32'd0);
        chk("l0_video_end", 32'(video), 32'd0);
        wait_cyc(t0 + LINE_T);

        // Line 1: reverse video code $81
        vram[0] = 8'h81;
        pulse(1'b0, 1'b1);
        wait_cyc(t0 + 3);
        chk("l1_glyph_addr", 32'(fetch_addr), 32'h10009);
        chk_pixels("l1_rev_pix", t0 + 16, 8'b1100_0011);
        wait_cyc(t0 + LINE_T);
        vram[0] = 8'h01;

        for (int ln = 2; ln < 8; ln++) begin
            gfx = (ln == 3);
            pulse(1'b0, 1'b1);
            if (ln == 3) begin
                wait_cyc(t0 + 3);
                chk("l3_gfx_glyph_addr", 32'(fetch_addr), 32'h1040B);
            end
            wait_cyc(t0 + LINE_T);
            gfx = 1'b0;
        end

        // 9th line: row 1, line 0
        pulse(1'b0, 1'b1);
        chk("row1_code_addr", 32'(fetch_addr), 32'h08028);
        wait_cyc(t0 + 3);
        chk("row1_glyph_addr", 32'(fetch_addr), 32'h10028);
        wait_cyc(t0 + LINE_T);

        // Row 1 line 1: col 0 code fetch acked 20 cycles late
        delay_next = 20;
        pulse(1'b0, 1'b1);
        wait_cyc(t0 + 10);
        chk("late_req_held", 32'(fetch_req), 32'd1);
        chk("late_addr_held", 32'(fetch_addr), 32'h08028);
        wait_cyc(t0 + 15);
        chk("late_underrun_pre", 32'(underrun), 32'd0);
        wait_cyc(t0 + 16);
        chk("late_underrun_set", 32'(underrun), 32'd1);
        chk("late_active", 32'(active), 32'd1);
        chk_pixels("late_col0_pix", t0 + 16, 8'h00);
        chk_pixels("late_col1_pix", t0 + 32, 8'b0011_1100);
        wait_cyc(t0 + LINE_T);
        chk("late_underrun_sticky", 32'(underrun), 32'd1);

        // Frame start together with line start
        pulse(1'b1, 1'b1);
        chk("fs_underrun_clr", 32'(underrun), 32'd0);
        chk("fs_ls_req", 32'(fetch_req), 32'd1);
        chk("fs_ls_addr", 32'(fetch_addr), 32'h08000);
        wait_cyc(t0 + LINE_T);
        for (int i = 1; i < TB_ROWS * 8; i++) begin
            run_line();
        end

        // Beyond the last row: line start ignored
        pulse(1'b0, 1'b1);
        chk("past_rows_req_t1", 32'(fetch_req), 32'd0);
        wait_cyc(t0 + 2);
        chk("past_rows_req_t2", 32'(fetch_req), 32'd0);
        wait_cyc(t0 + 16);
        chk("past_rows_active", 32'(active), 32'd0);
        wait_cyc(t0 + 20);
        chk("past_rows_video", 32'(video), 32'd0);

        // Reset during a held request while pixels are shifting
        pulse(1'b1, 1'b1);
        wait_cyc(t0 + 16);
        delay_next = 30;
        wait_cyc(t0 + 20);
        chk("pre_rst_req", 32'(fetch_req), 32'd1);
        chk("pre_rst_active", 32'(active), 32'd1);
        chk("pre_rst_video", 32'(video), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req_drop", 32'(fetch_req), 32'd0);
        chk("rst_active_drop", 32'(active), 32'd0);
        chk("rst_video_drop", 32'(video), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse(1'b0, 1'b1);
        chk("post_rst_req", 32'(fetch_req), 32'd1);
        chk("post_rst_addr", 32'(fetch_addr), 32'h08000);
        wait_cyc(t0 + LINE_T);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
